d_ff_pipe: RTL

Parametrised multi-stage D-register pipeline: a delay line of DEPTH stages, each WIDTH bits wide, built from enabled D flip-flops.
Adds per-stage valid tracking, global stall (en), flush, an occupancy counter and a selectable tap output.
Used wherever the design needs a fixed, stallable latency on a datapath, replacing hand-chained single D_ff instances.

---
 rtl/d_ff_pipe_pkg.sv | 23 ++
 rtl/d_ff_pipe_en.sv | 22 ++
 rtl/d_ff_pipe.sv | 85 ++++++++
 3 files changed

// File: rtl/d_ff_pipe_pkg.sv
// Shared constants and width helpers for the d_ff_pipe delay line.
package d_ff_pipe_pkg;

  localparam int RESET_VAL_DEFAULT = 0;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

  // Tap select needs at least one bit even for a single stage.
  function automatic int tsw_f(input int depth);
    return (clog2_f(depth) < 1) ? 1 : clog2_f(depth);
  endfunction

  function automatic int ocw_f(input int depth);
    return (clog2_f(depth + 1) < 1) ? 1 : clog2_f(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_en.sv
// Single WIDTH-bit enabled register with synchronous reset to a parametrised value.
module d_ff_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)     data_q <= RESET_VAL;
    else if (en) data_q <= D;
  end

  assign Q = data_q;

endmodule

// File: rtl/d_ff_pipe.sv
// Stallable, flushable DEPTH-stage delay line with valid tracking, occupancy and tap.
module d_ff_pipe
  import d_ff_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           D,
  input  logic [tsw_f(DEPTH)-1:0]    tap_sel,
  output logic [WIDTH-1:0]           Q,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           tap_Q,
  output logic                       tap_valid,
  output logic [ocw_f(DEPTH)-1:0]    occupancy
);

  localparam int TSW = tsw_f(DEPTH);
  localparam int OCW = ocw_f(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stg_in, stg_q;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [OCW-1:0]              occ_q, occ_d;

  // Data stages shift on en alone; flush only touches the valid side.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    if (g == 0) begin : g_head
      assign stg_in[g] = D;
    end else begin : g_body
      assign stg_in[g] = stg_q[g-1];
    end
    d_ff_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stg (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .D   (stg_in[g]),
      .Q   (stg_q[g])
    );
  end

  always_comb begin
    vld_d = vld_q;
    occ_d = occ_q;
    if (flush) begin
      vld_d = '0;
      occ_d = '0;
    end else if (en) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) vld_d[i] = vld_q[i-1];
      occ_d = occ_q + OCW'(in_valid) - OCW'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    tap_Q     = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TSW'(i)) begin
        tap_Q     = stg_q[i];
        tap_valid = vld_q[i];
      end
    end
  end

  assign Q         = stg_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule
